// File: rtl/en_delay_line_pkg.sv
// Shared constants and helpers for the enabled delay line.
package en_delay_line_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Counter width able to hold 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dl_stage.sv
// One stage of the delay line: enabled data+valid register with sync reset and flush.
module dl_stage
    import en_delay_line_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q       <= RESET_VAL;
            q_valid <= 1'b0;
        end else if (enable) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/en_delay_line.sv
// Stallable WIDTH x DEPTH delay line with per-stage valid and registered occupancy.
// Define EN_DELAY_LINE_SVA_EN to compile the embedded assertions and covers.
module en_delay_line
    import en_delay_line_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         d,
    input  logic                     d_valid,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic [WIDTH*DEPTH-1:0]   taps,
    output logic [DEPTH-1:0]         tap_valid,
    output logic [occ_w(DEPTH)-1:0]  occupancy,
    output logic                     full,
    output logic                     empty
);

    localparam int OW = occ_w(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             valid;
    } stage_t;

    stage_t               head;
    stage_t [DEPTH-1:0]   stg;
    logic   [DEPTH:0]     vld_pipe;

    assign head = '{data: d, valid: d_valid};

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        stage_t src;
        if (i == 0) begin : g_head
            assign src = head;
        end else begin : g_link
            assign src = stg[i-1];
        end

        dl_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .enable  (enable),
            .d       (src.data),
            .d_valid (src.valid),
            .q       (stg[i].data),
            .q_valid (stg[i].valid)
        );

        assign taps[i*WIDTH +: WIDTH] = stg[i].data;
        assign tap_valid[i]           = stg[i].valid;
    end

    // vld_pipe[0] is the entering valid, vld_pipe[DEPTH] the one leaving on shift.
    assign vld_pipe = {tap_valid, d_valid};

    always_ff @(posedge clk) begin
        if (reset || flush)
            occupancy <= '0;
        else if (enable)
            occupancy <= occupancy + OW'(vld_pipe[0]) - OW'(vld_pipe[DEPTH]);
    end

    assign q       = stg[DEPTH-1].data;
    assign q_valid = stg[DEPTH-1].valid;
    assign full    = (occupancy == OW'(DEPTH));
    assign empty   = (occupancy == '0);

`ifdef EN_DELAY_LINE_SVA_EN
    logic adv;
    assign adv = enable & !reset & !flush;

    a_reset: assert property (@(posedge clk)
        reset |=> (!q_valid && occupancy == '0 && q == RESET_VAL));
    a_flush: assert property (@(posedge clk) flush |=> empty);
    a_hold:  assert property (@(posedge clk)
        (!enable & !reset & !flush) |=> ($stable(taps) && $stable(tap_valid)));
    a_occ:   assert property (@(posedge clk) disable iff (reset)
        occupancy == OW'($countones(tap_valid)));
    a_range: assert property (@(posedge clk) disable iff (reset)
        occupancy <= OW'(DEPTH));

    for (genvar i = 0; i < DEPTH; i++) begin : g_sva
        if (i == 0) begin : g_first
            a_shift: assert property (@(posedge clk) adv |=> stg[0] === $past(head));
        end else begin : g_rest
            a_shift: assert property (@(posedge clk) adv |=> stg[i] === $past(stg[i-1]));
        end
    end

    // A valid bit can only reach the output after DEPTH enabled shifts.
    c_full:         cover property (@(posedge clk) disable iff (reset) full);
    c_enable:       cover property (@(posedge clk) disable iff (reset) $rose(q_valid));
    c_flush_enable: cover property (@(posedge clk) flush && enable);
`endif

endmodule
